// File: rtl/fp_add_pkg.sv
// Shared constants and types for the single-precision adder datapath.
package fp_add_pkg;

    localparam int EXP_W   = 8;
    localparam int MAN_W   = 23;
    localparam int SIG_W   = MAN_W + 5;
    localparam int BIAS    = 127;
    localparam int EXP_MAX = (1 << EXP_W) - 1;

    // Guard / round / sticky positions inside the normalized significand.
    localparam int L_IDX = 3;
    localparam int G_IDX = 2;
    localparam int R_IDX = 1;
    localparam int S_IDX = 0;

    typedef enum logic [1:0] {
        RND_RNE = 2'b00,
        RND_RZ  = 2'b01,
        RND_RU  = 2'b10,
        RND_RD  = 2'b11
    } rnd_e;

endpackage

// File: rtl/fp_rne_inc.sv
// Rounding-increment decision from the LSB, guard, round and sticky bits.
module fp_rne_inc
    import fp_add_pkg::*;
(
    input  logic i_l,
    input  logic i_g,
    input  logic i_r,
    input  logic i_s,
    input  logic i_sign,
    input  rnd_e i_mode,
    output logic o_inc
);

    always_comb begin
        o_inc = 1'b0;
        case (i_mode)
            RND_RNE: o_inc = i_g & (i_r | i_s | i_l);
            RND_RZ:  o_inc = 1'b0;
            RND_RU:  o_inc = ~i_sign & (i_g | i_r | i_s);
            RND_RD:  o_inc = i_sign & (i_g | i_r | i_s);
            default: o_inc = 1'b0;
        endcase
    end

endmodule

// File: rtl/fp_round_pack.sv
// Round, renormalize and pack stage of the FP adder (two-stage, valid/ready).
// FP_ROUND_MODES_EN adds the rnd_mode port (RNE/RZ/RU/RD); otherwise RNE only.
module fp_round_pack #(
    parameter int EXP_W = fp_add_pkg::EXP_W,
    parameter int MAN_W = fp_add_pkg::MAN_W,
    parameter int BIAS  = fp_add_pkg::BIAS
) (
    input  logic                     clk,
    input  logic                     rst_n,
`ifdef FP_ROUND_MODES_EN
    input  logic [1:0]               rnd_mode,
`endif
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     sign_in,
    input  logic [EXP_W+1:0]         exp_in,
    input  logic [MAN_W+4:0]         sig_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     result,
    output logic                     ovf,
    output logic                     unf,
    output logic                     inexact
);
    import fp_add_pkg::*;

    localparam int SIG_W   = MAN_W + 5;
    localparam int HID_IDX = SIG_W - 2;
    localparam int CRY_IDX = SIG_W - 1;
    localparam int EXP_MAX = (1 << EXP_W) - 1;
    localparam logic signed [EXP_W+1:0] C_EXP_MAX = (EXP_W+2)'(EXP_MAX);
    localparam logic signed [EXP_W+1:0] C_ONE     = (EXP_W+2)'(1);
    localparam logic signed [EXP_W+1:0] C_ZERO    = '0;

    logic                     r_s1_valid;
    logic                     r_s1_sign;
    logic signed [EXP_W+1:0]  r_s1_exp;
    logic [MAN_W:0]           r_s1_sig;
    logic                     r_s1_zero;
    logic                     r_s1_inc;
    logic                     r_s1_inx;

    logic                     r_s2_valid;
    logic [EXP_W+MAN_W:0]     r_result;
    logic                     r_ovf;
    logic                     r_unf;
    logic                     r_inexact;

    logic                     w_s1_adv;
    logic                     w_in_ready;
    logic                     w_inc;
    rnd_e                     w_mode;
    logic [MAN_W+1:0]         w_m;
    logic [MAN_W-1:0]         w_frac;
    logic signed [EXP_W+1:0]  w_e;
    logic [EXP_W+MAN_W:0]     w_result;
    logic                     w_ovf;
    logic                     w_unf;
    logic                     w_inx;
    logic                     w_sat;

    assign w_s1_adv   = ~r_s2_valid | out_ready;
    assign w_in_ready = ~r_s1_valid | w_s1_adv;

`ifdef FP_ROUND_MODES_EN
    rnd_e r_s1_mode;
    assign w_mode = rnd_e'(rnd_mode);
    // Overflow saturates to max finite when rounding toward zero or away from infinity.
    assign w_sat  = (r_s1_mode == RND_RZ) |
                    ((r_s1_mode == RND_RU) & r_s1_sign) |
                    ((r_s1_mode == RND_RD) & ~r_s1_sign);
`else
    assign w_mode = RND_RNE;
    assign w_sat  = 1'b0;
`endif

    fp_rne_inc u_inc (
        .i_l    (sig_in[L_IDX]),
        .i_g    (sig_in[G_IDX]),
        .i_r    (sig_in[R_IDX]),
        .i_s    (sig_in[S_IDX]),
        .i_sign (sign_in),
        .i_mode (w_mode),
        .o_inc  (w_inc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_exp   <= '0;
            r_s1_sig   <= '0;
            r_s1_zero  <= 1'b0;
            r_s1_inc   <= 1'b0;
            r_s1_inx   <= 1'b0;
`ifdef FP_ROUND_MODES_EN
            r_s1_mode  <= RND_RNE;
`endif
        end else begin
            if (w_in_ready) r_s1_valid <= in_valid;
            if (in_valid && w_in_ready) begin
                r_s1_sign <= sign_in;
                r_s1_exp  <= exp_in;
                r_s1_sig  <= sig_in[HID_IDX:L_IDX];
                r_s1_zero <= (sig_in == '0);
                r_s1_inc  <= w_inc;
                r_s1_inx  <= sig_in[G_IDX] | sig_in[R_IDX] | sig_in[S_IDX];
`ifdef FP_ROUND_MODES_EN
                r_s1_mode <= w_mode;
`endif
            end
        end
    end

    always_comb begin
        w_m = {1'b0, r_s1_sig} + {{(MAN_W+1){1'b0}}, r_s1_inc};
        // Carry out of the rounded significand means it became exactly 2.0.
        if (w_m[MAN_W+1]) begin
            w_frac = w_m[MAN_W:1];
            w_e    = r_s1_exp + C_ONE;
        end else begin
            w_frac = w_m[MAN_W-1:0];
            w_e    = r_s1_exp;
        end

        w_result = {r_s1_sign, w_e[EXP_W-1:0], w_frac};
        w_ovf    = 1'b0;
        w_unf    = 1'b0;
        w_inx    = r_s1_inx;

        if (r_s1_zero) begin
            w_result = {r_s1_sign, {(EXP_W+MAN_W){1'b0}}};
            w_inx    = 1'b0;
        end else if (w_e >= C_EXP_MAX) begin
            w_ovf = 1'b1;
            w_inx = 1'b1;
            if (w_sat) w_result = {r_s1_sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
            else       w_result = {r_s1_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (w_e <= C_ZERO) begin
            w_result = {r_s1_sign, {(EXP_W+MAN_W){1'b0}}};
            w_unf    = 1'b1;
            w_inx    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_result   <= '0;
            r_ovf      <= 1'b0;
            r_unf      <= 1'b0;
            r_inexact  <= 1'b0;
        end else if (w_s1_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_result  <= w_result;
                r_ovf     <= w_ovf;
                r_unf     <= w_unf;
                r_inexact <= w_inx;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_s2_valid;
    assign result    = r_result;
    assign ovf       = r_ovf;
    assign unf       = r_unf;
    assign inexact   = r_inexact;

    a_sig_form: assert property (@(posedge clk) disable iff (!rst_n)
        (in_valid && w_in_ready) |-> !(sig_in[CRY_IDX] || (sig_in != '0 && !sig_in[HID_IDX])));

    a_bias_range: assert property (@(posedge clk) disable iff (!rst_n) BIAS < EXP_MAX);

endmodule

// File: doc/fp_round_pack.md
Name: fp_round_pack

Overview:
- Final stage of the single-precision FP adder datapath. Directly consumes the normalized 28-bit significand from the left-shift normalizer, plus the adjusted exponent and sign.
- Performs round-to-nearest-even, renormalizes on rounding carry-out, detects overflow and underflow, and packs an IEEE-754 binary32 word.
- Two-stage pipeline with valid/ready handshake on both sides.

Parameters:
- EXP_W, 8, exponent field width
- MAN_W, 23, stored fraction width; significand width SIG_W = MAN_W+5 = 28, derived and not overridable
- BIAS, 127, exponent bias; the overflow threshold is 2^EXP_W-1 = 255

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  stage can accept a beat
- sign_in  in  1  result sign
- exp_in  in  EXP_W+2  signed two's-complement biased exponent, already adjusted by the normalize shift count
- sig_in  in  SIG_W  bit27 = 0 (carry slot), bit26 = hidden one, [25:3] = fraction, bit2 = G, bit1 = R, bit0 = S (sticky)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- result  out  1+EXP_W+MAN_W  packed binary32
- ovf  out  1  overflow to infinity
- unf  out  1  underflow flushed to zero
- inexact  out  1  G|R|S nonzero, or ovf/unf

Behaviour:
- Reset (async, rst_n low): both stage valid bits clear; out_valid = 0; result, ovf, unf, inexact = 0. in_ready = 1 the first cycle after release.
- Handshake:
  - A transfer occurs when valid & ready are both high on a rising edge.
  - in_ready = !s1_valid | s1_adv, where s1_adv = !s2_valid | out_ready. This is a global-stall pipeline; in_ready is combinational from out_ready.
  - out_valid = s2_valid. result and flags hold stable while out_valid & !out_ready.
  - No beat is dropped or duplicated. Beats leave in order.
- Latency: 2 cycles from input accept to out_valid. Throughput is 1 beat/cycle when out_ready = 1.
- Stage 1 registers:
  - sign, exp, sig[26:3], zero flag (sig_in == 0).
  - inc = G & (R | S | L), where L = sig[3].
  - inx = G | R | S.
- Stage 2:
  - m = {1'b0, sig[26:3]} + inc (25 bits).
  - If m[24] = 1: fraction = m[23:1] (which is 0), e = exp+1. Else fraction = m[22:0], e = exp.
- Packing priority:
  1. zero flag: result = {sign, 0, 0}; ovf = unf = inexact = 0.
  2. e >= 255: result = {sign, 8'hFF, 0}; ovf = 1; inexact = 1.
  3. e <= 0 (signed): result = {sign, 0, 0}; unf = 1; inexact = 1. No subnormals.
  4. Otherwise: result = {sign, e[7:0], fraction}; inexact = inx.
- sig_in[27] = 1 or a nonzero sig_in with bit26 = 0 is a protocol violation. Output is unspecified; an assertion fires in simulation.
- Simultaneous accept and emit in the same cycle is legal and required at full rate.
- Reset asserted mid-operation: in-flight beats are discarded and no partial output appears.

Optional Feature:
- FP_ROUND_MODES_EN
- Defined: adds input port rnd_mode[1:0], sampled with the beat: 00 RNE, 01 RZ (inc = 0), 10 RU (inc = !sign & inx), 11 RD (inc = sign & inx).
  - Overflow under RZ, or in the direction away from infinity, yields max finite {sign, 8'hFE, all-ones}, still with ovf = 1.
- Undefined: no port; RNE only.

Decomposition:
- Shared package fp_add_pkg: EXP_W, MAN_W, SIG_W, BIAS, EXP_MAX, the rounding-mode enum (rnd_e), and the GRS bit-index constants.
- One natural sub-module: fp_rne_inc, a combinational rounding-increment decision (inputs L, G, R, S, sign, mode; output inc).

Test Plan:
- sig=0x4000000, exp=127, sign=0 -> after 2 cycles result=0x3F800000, inexact=0.
- Ties:
  - sig=0x4000004 (L=0, G=1, R=S=0) -> 0x3F800000, inexact=1.
  - sig=0x400000C (L=1, G=1) -> 0x3F800002.
- Carry-out: sig=0x7FFFFFC, exp=127 -> 0x40000000. The same sig with exp=254 -> 0x7F800000, ovf=1.
- Underflow and zero:
  - exp=0, sig=0x4000000, sign=1 -> 0x80000000, unf=1.
  - sig=0, sign=1 -> 0x80000000, all flags 0.
- Backpressure: stream 5 beats with out_ready low for cycles 2-5 -> in_ready drops after 2 held beats; all 5 outputs appear in order, none lost or duplicated.
- Reset pulse while 2 beats are in flight -> out_valid=0 immediately; no stale beat emitted after release.
